// File: rtl/package_settings_v2.sv
// ---------------------------------------------------------------------------
// package_settings_v2
// Shared settings for the ADC pulse emulator slice.
//   SIZE_ADC_DATA : width of one emulated ADC sample
//   emu_state_t   : two-state control type (idle / pulse in flight)
// ---------------------------------------------------------------------------
package package_settings_v2;

   localparam int SIZE_ADC_DATA = 14;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } emu_state_t;

endpackage : package_settings_v2

// File: rtl/adc_pulse_emulator_exp_decay_acc.sv
// ---------------------------------------------------------------------------
// exp_decay_acc
// Saturating fixed-point accumulator with exponential decay.
// On every sample_en the accumulator loses acc>>DECAY_SHIFT (at least 1 while
// nonzero) and optionally gains add_amp<<FRAC_BITS; the sum clamps at
// all-ones instead of wrapping.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   sample_en       : commit acc_next into the accumulator
//   add_en, add_amp : amplitude injected on this sample
//   acc_next        : value the accumulator takes on this sample
// ---------------------------------------------------------------------------
import package_settings_v2::*;

module exp_decay_acc #(
   parameter int ACC_W       = 23,
   parameter int AMP_W       = 14,
   parameter int FRAC_BITS   = 8,
   parameter int DECAY_SHIFT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic             add_en,
   input  logic [AMP_W-1:0] add_amp,
   output logic [ACC_W-1:0] acc_next
);

   localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
   localparam logic [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
   localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] dec_s;
   logic [ACC_W-1:0] add_s;
   logic [ACC_W:0]   sum_s;

   // Next accumulator value: decay (floor of 1 so the tail terminates), add, clamp
   always_comb begin
      dec_s = acc_r >> DECAY_SHIFT;
      if ((acc_r != ACC_ZERO) && (dec_s == ACC_ZERO)) begin
         dec_s = ACC_ONE;
      end else begin
         dec_s = acc_r >> DECAY_SHIFT;
      end

      if (add_en) begin
         add_s = {{(ACC_W-AMP_W){1'b0}}, add_amp} << FRAC_BITS;
      end else begin
         add_s = ACC_ZERO;
      end

      // dec never exceeds acc, so the subtraction cannot underflow
      sum_s = {1'b0, acc_r - dec_s} + {1'b0, add_s};

      if (sum_s[ACC_W]) begin
         acc_next = ACC_MAX;
      end else begin
         acc_next = sum_s[ACC_W-1:0];
      end
   end

   // Accumulator register, updated only at the sample rate
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r <= ACC_ZERO;
      end else if (sample_en) begin
         acc_r <= acc_next;
      end else begin
         acc_r <= acc_r;
      end
   end

endmodule : exp_decay_acc

// File: rtl/adc_pulse_emulator.sv
// ---------------------------------------------------------------------------
// adc_pulse_emulator
// Emulates an ADC observing exponentially decaying pulses on a pedestal.
// Used as the stimulus source for the trapezoidal shaping filter.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   sample_en    : ADC sample-rate strobe (one-cycle pulse)
//   trig         : pulse request; amplitude is captured with it
//   amplitude    : pulse height in ADC LSB
//   clr_ovf      : clears the sticky overflow flag
//   output_data  : emulated ADC sample, updated one clock after sample_en
//   data_valid   : one-cycle strobe marking a new output_data
//   busy         : a pulse is pending or still decaying
//   overflow     : sticky, set when an emitted sample saturated
//   pile_count   : saturating count of dropped (piled-up) triggers
// ---------------------------------------------------------------------------
import package_settings_v2::*;

module adc_pulse_emulator #(
   parameter int SIZE_ADC_DATA = package_settings_v2::SIZE_ADC_DATA,
   parameter int FRAC_BITS     = 8,
   parameter int DECAY_SHIFT   = 4,
   parameter int BASELINE      = 100
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_en,
   input  logic                     trig,
   input  logic [SIZE_ADC_DATA-1:0] amplitude,
   input  logic                     clr_ovf,
   output logic [SIZE_ADC_DATA-1:0] output_data,
   output logic                     data_valid,
   output logic                     busy,
   output logic                     overflow,
   output logic [7:0]               pile_count
);

   localparam int ACC_W = SIZE_ADC_DATA + FRAC_BITS + 1;
   localparam int SUM_W = SIZE_ADC_DATA + 2;

   localparam logic [ACC_W-1:0]         ACC_ZERO = {ACC_W{1'b0}};
   localparam logic [SUM_W-1:0]         BASE_EXT = SUM_W'(BASELINE);
   localparam logic [SUM_W-1:0]         MAX_EXT  = {2'b00, {SIZE_ADC_DATA{1'b1}}};
   localparam logic [SIZE_ADC_DATA-1:0] DATA_ZERO = {SIZE_ADC_DATA{1'b0}};

   emu_state_t                state_r;
   emu_state_t                state_next_s;
   logic                      busy_next_s;

   logic                      pend_r;
   logic [SIZE_ADC_DATA-1:0]  pend_amp_r;
   logic                      pend_next_s;
   logic [SIZE_ADC_DATA-1:0]  pend_amp_next_s;
   logic                      drop_s;

   logic                      add_en_s;
   logic [SIZE_ADC_DATA-1:0]  add_amp_s;
   logic [ACC_W-1:0]          acc_next_s;

   logic [SUM_W-1:0]          out_sum_s;
   logic                      out_sat_s;
   logic [SIZE_ADC_DATA-1:0]  out_val_s;

   logic [SIZE_ADC_DATA-1:0]  output_data_r;
   logic                      data_valid_r;
   logic                      busy_r;
   logic                      overflow_r;
   logic [7:0]                pile_r;

   exp_decay_acc #(
      .ACC_W       (ACC_W),
      .AMP_W       (SIZE_ADC_DATA),
      .FRAC_BITS   (FRAC_BITS),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_acc (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en),
      .add_en    (add_en_s),
      .add_amp   (add_amp_s),
      .acc_next  (acc_next_s)
   );

   // Pending-pulse bookkeeping: what this sample injects and what stays pending.
   // A trig alongside sample_en with nothing pending goes straight into this
   // sample; with a pend outstanding, the old pend is consumed and the new
   // trig becomes the next pend.
   always_comb begin
      add_en_s        = 1'b0;
      add_amp_s       = amplitude;
      pend_next_s     = pend_r;
      pend_amp_next_s = pend_amp_r;
      drop_s          = 1'b0;
      if (sample_en) begin
         add_en_s    = pend_r | trig;
         add_amp_s   = pend_r ? pend_amp_r : amplitude;
         pend_next_s = pend_r & trig;
         if (pend_r && trig) begin
            pend_amp_next_s = amplitude;
         end else begin
            pend_amp_next_s = pend_amp_r;
         end
      end else if (trig) begin
         if (pend_r) begin
            drop_s = 1'b1;
         end else begin
            pend_next_s     = 1'b1;
            pend_amp_next_s = amplitude;
         end
      end else begin
         drop_s = 1'b0;
      end
   end

   // Output sample: pedestal plus integer part of acc_next, clamped to full scale
   always_comb begin
      out_sum_s = BASE_EXT + {1'b0, acc_next_s[ACC_W-1:FRAC_BITS]};
      out_sat_s = (out_sum_s > MAX_EXT);
      if (out_sat_s) begin
         out_val_s = MAX_EXT[SIZE_ADC_DATA-1:0];
      end else begin
         out_val_s = out_sum_s[SIZE_ADC_DATA-1:0];
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (trig) begin
               state_next_s = ST_ACTIVE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (sample_en && (acc_next_s == ACC_ZERO) && !pend_next_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_ACTIVE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // FSM output decode; busy is registered alongside the state so it always matches it
   always_comb begin
      busy_next_s = 1'b0;
      case (state_next_s)
         ST_ACTIVE: busy_next_s = 1'b1;
         ST_IDLE:   busy_next_s = 1'b0;
         default:   busy_next_s = 1'b0;
      endcase
   end

   // Pend, output sample, strobe, busy, overflow and pile-up registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_r        <= 1'b0;
         pend_amp_r    <= DATA_ZERO;
         output_data_r <= DATA_ZERO;
         data_valid_r  <= 1'b0;
         busy_r        <= 1'b0;
         overflow_r    <= 1'b0;
         pile_r        <= 8'd0;
      end else begin
         pend_r     <= pend_next_s;
         pend_amp_r <= pend_amp_next_s;
         busy_r     <= busy_next_s;
         data_valid_r <= sample_en;
         if (sample_en) begin
            output_data_r <= out_val_s;
         end else begin
            output_data_r <= output_data_r;
         end
         // set wins over clear
         if (sample_en && out_sat_s) begin
            overflow_r <= 1'b1;
         end else if (clr_ovf) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
         if (drop_s && (pile_r != 8'hFF)) begin
            pile_r <= pile_r + 8'd1;
         end else begin
            pile_r <= pile_r;
         end
      end
   end

   assign output_data = output_data_r;
   assign data_valid  = data_valid_r;
   assign busy        = busy_r;
   assign overflow    = overflow_r;
   assign pile_count  = pile_r;

endmodule : adc_pulse_emulator

// File: doc/adc_pulse_emulator.md
ADC_PULSE_EMULATOR -- requirements
Module: adc_pulse_emulator

Interface
REQ-001 Parameter SIZE_ADC_DATA, default from package_settings_v2 (14): ADC sample width.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of the internal accumulator.
REQ-003 Parameter DECAY_SHIFT, default 4: per-sample decay divisor exponent, giving decay factor (1 - 2^-DECAY_SHIFT).
REQ-004 Parameter BASELINE, default 100: constant pedestal added to every output sample.
REQ-005 Port clk, input, 1: system clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port sample_en, input, 1: ADC sample-rate strobe, one-cycle pulse.
REQ-008 Port trig, input, 1: pulse request, one-cycle pulse.
REQ-009 Port amplitude, input, SIZE_ADC_DATA: pulse height in ADC LSB, sampled with trig.
REQ-010 Port clr_ovf, input, 1: clears the sticky overflow flag.
REQ-011 Port output_data, output, SIZE_ADC_DATA: emulated ADC sample, the stimulus source for the trapezoidal shaping filter.
REQ-012 Port data_valid, output, 1: one-cycle strobe marking a new output_data.
REQ-013 Port busy, output, 1: a pulse is pending or still decaying.
REQ-014 Port overflow, output, 1: sticky flag set when an output sample saturated.
REQ-015 Port pile_count, output, 8: saturating count of dropped triggers.

Function
REQ-016 Internal accumulator acc SHALL be SIZE_ADC_DATA+FRAC_BITS+1 bits, unsigned.
REQ-017 A trig SHALL latch amplitude into a pending register; the pending amplitude is applied at the next sample_en, including a sample_en in the same cycle as trig.
REQ-018 On sample_en: acc_next = acc - dec + (pending ? amplitude<<FRAC_BITS : 0), where dec = acc>>DECAY_SHIFT.
REQ-019 If acc is nonzero and acc>>DECAY_SHIFT is 0, dec SHALL be 1 so that acc reaches zero in a bounded number of samples.
REQ-020 acc SHALL saturate at all-ones and never wrap.
REQ-021 One cycle after sample_en, output_data SHALL equal min(BASELINE + (acc_next>>FRAC_BITS), 2^SIZE_ADC_DATA-1), and data_valid SHALL be 1 for exactly that cycle.
REQ-022 Latency from sample_en to data_valid SHALL be exactly 1 clock; output_data SHALL hold its value between strobes.
REQ-023 A trig arriving while a pend is already outstanding SHALL be dropped, and pile_count SHALL increment, saturating at 255.
REQ-024 A trig on the same cycle as a sample_en that consumes the current pend SHALL be latched as the new pend, not dropped.
REQ-025 The state machine SHALL have two states. IDLE: acc==0 and no pend. ACTIVE: otherwise. IDLE->ACTIVE on trig. ACTIVE->IDLE when acc_next==0 and no pend.
REQ-026 busy SHALL be 1 exactly when the state is ACTIVE.
REQ-027 overflow SHALL be set in the cycle a saturated sample is emitted and cleared by clr_ovf; if both occur in the same cycle, set wins.
REQ-028 sample_en with no trig while IDLE SHALL still emit BASELINE with data_valid.

Reset
REQ-029 When reset is low: acc=0, pend=0, state=IDLE, output_data=0, data_valid=0, busy=0, overflow=0, pile_count=0, applied asynchronously, including mid-pulse.
REQ-030 The first sample_en after reset release SHALL produce output_data=BASELINE.

Structure
REQ-031 SIZE_ADC_DATA and the two-state enum type SHALL live in package_settings_v2; FRAC_BITS, DECAY_SHIFT and BASELINE SHALL be module parameters.
REQ-032 The block SHALL be one module; a sub-module for the saturating decay accumulator, exp_decay_acc, is permitted.

Verification (N=14, FRAC_BITS=8, DECAY_SHIFT=4, BASELINE=100)
REQ-033 Idle: reset, then sample_en -> output_data=100 one cycle later with data_valid=1 and busy=0.
REQ-034 Single pulse: trig with amplitude=1000 plus sample_en -> output 1100; next sample 1037 (acc 937.5); then monotonic decay back to 100 with busy falling.
REQ-035 Saturation: amplitude=16383 -> output 16383 and overflow=1; overflow stays set through the decay until clr_ovf.
REQ-036 Pile-up: two trigs before one sample_en -> pile_count=1 and output 1100, not 2100; a trig coincident with the consuming sample_en -> pile_count unchanged.
REQ-037 Reset mid-decay: assert reset at sample 3 of the REQ-034 pulse -> all outputs 0 immediately; the next post-reset sample is 100.
REQ-038 Tail: amplitude=1 -> output returns to 100 and busy=0 within 2^(FRAC_BITS) samples.
